// File: rtl/uart_tx.sv
// uart_tx: UART transmit serialiser.
//
// Sends one W_DATA-bit word per accepted request as: start bit (0), data
// LSB first, optional parity bit, one stop bit (1). Every serial bit lasts
// CLKS_PER_BIT clock cycles, timed by an internal baud counter.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-low reset
//   start  request to send, accepted when busy is low
//   data   word to send, captured on acceptance
//   tx     serial line, idles high
//   busy   high from the cycle after acceptance until the frame ends
//   done   one-cycle pulse when the stop bit completes

package uart_pkg;
    parameter int W_DATA = 8;
    typedef logic [W_DATA-1:0] data_t;
endpackage

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  data_t data,
    output logic  tx,
    output logic  busy,
    output logic  done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (W_DATA > 1) ? $clog2(W_DATA) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    data_t              shreg_q, shreg_d;
    logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [BAUD_W-1:0]  baudCnt_q, baudCnt_d;
    logic               parity_q, parity_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               baudLast;

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // Last cycle of the current serial bit; every state transition except
    // acceptance happens on this boundary.
    assign baudLast = (baudCnt_q == BAUD_W'(CLKS_PER_BIT - 1));

    // State and datapath registers. Reset forces the line high at once so an
    // aborted frame never leaves a low level on tx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitCnt_q  <= '0;
            baudCnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitCnt_q  <= bitCnt_d;
            baudCnt_q <= baudCnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. The outputs are registered, so tx_d is the level the
    // line takes in the next cycle: each transition loads the value of the
    // bit that is about to begin.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitCnt_d  = bitCnt_q;
        baudCnt_d = baudCnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != IDLE) begin
            baudCnt_d = baudLast ? '0 : baudCnt_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                baudCnt_d = '0;
                if (start) begin
                    // Parity comes from the captured word, so later changes
                    // on the data port cannot affect this frame.
                    state_d  = START;
                    shreg_d  = data;
                    parity_d = (^data) ^ PARITY_ODD;
                    bitCnt_d = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (baudLast) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (baudLast) begin
                    shreg_d = shreg_q >> 1;
                    if (bitCnt_q == BIT_W'(W_DATA - 1)) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_W'(1);
                        tx_d     = shreg_d[0];
                    end
                end
            end
            PARITY: begin
                if (baudLast) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (baudLast) begin
                    // busy drops together with the done pulse, which lets a
                    // waiting request be accepted in the done cycle.
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit path: takes one W_DATA-bit word per request and serialises it onto a single line.
- Frame order: start bit, data LSB first, optional parity bit, one stop bit.
- Output is bit-compatible with the team's UART receiver shift register: LSB shifted first, parity is the XOR of the data bits.
- Sits between the host-side data source and the tx pin; the baud divider is internal.

Parameters:
W_DATA, 8 (uart_pkg), data bits per frame; data port uses data_t
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
PARITY_EN, 1, 1 = insert parity bit after data, 0 = omit
PARITY_ODD, 0, 0 = even parity (bit = XOR of data), 1 = odd (bit = ~XOR of data)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
start  input  1  request to send; sampled on rising clk
data  input  W_DATA (data_t)  word to send; captured when request accepted
tx  output  1  serial line, idles high
busy  output  1  high from cycle after acceptance until frame ends
done  output  1  one-cycle pulse when stop bit completes

Behaviour:
- Reset (rst low, async): state IDLE, tx=1, busy=0, done=0, shift register, bit counter and baud counter cleared. A reset mid-frame aborts the frame immediately; tx returns high with no glitch low.
- All outputs are registered.
- Acceptance: start=1 && busy=0 at a rising edge. data is latched into the shift register and parity is computed from the latched word. start while busy=1 is ignored; data changes after acceptance have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On acceptance -> START; tx=0 and busy=1 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx=shreg[0] for CLKS_PER_BIT cycles per bit. The register shifts right at each bit boundary. Bit counter runs 0..W_DATA-1; after the last bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx=parity bit for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE. At that edge busy falls and done=1 for exactly one cycle.
- Baud counter counts 0..CLKS_PER_BIT-1, reloads to 0 at each bit boundary, and is held at 0 in IDLE.
- Latency: start accepted at edge N -> tx falls at edge N+1.
- Frame length: (2+W_DATA+PARITY_EN)*CLKS_PER_BIT cycles of busy=1. Default: 11*16=176.
- Back-to-back: during the done cycle busy=0, so start=1 in that cycle is accepted. The next start bit begins one cycle after the done edge; tx stays high for that one cycle, which is the minimum inter-frame idle (1 clk).
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit counter is $clog2(W_DATA) bits. No wrap beyond terminal count.
- done never asserts without a preceding accepted request. done never asserts after a reset-aborted frame.

Test Plan:
- Reset idle: hold rst low 3 cycles, release, no start for 50 cycles -> tx=1, busy=0, done=0 throughout.
- Even parity frame (CLKS_PER_BIT=4, PARITY_EN=1, even): send 0xA5 -> tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop). busy high 44 cycles; done pulses once at end.
- Odd parity / no parity: 0x07 with even parity -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. With PARITY_EN=0 -> frame 0,1,1,1,0,0,0,0,0,1, busy 40 cycles.
- Ignore while busy: send 0x3C, pulse start with data=0xFF mid-frame -> only 0x3C transmitted, one done pulse, no second frame.
- Back-to-back: hold start=1 with data 0x55 then 0xAA presented in the done cycle -> second start bit begins 1 cycle after done. A receiver model decodes 0x55 then 0xAA, both with parity OK.
- Reset mid-frame: assert rst during DATA bit 3 of 0x81 -> tx=1 and busy=0 immediately, no done. A new send of 0x81 after release yields a complete, correct frame.
